accumulatore_prodotti: RTL and testbench

- Downstream stage of the 2-bit combinational multiplier `moltiplicatore`.
- Consumes a stream of 4-bit products and accumulates N of them into a saturating sum, then presents that sum to the next stage.
- Uses a valid/ready handshake on both sides.
- Registers the multiplier output, making the datapath sequential (multiply-accumulate over a block of N operand pairs).

---
 rtl/accumulatore_prodotti.sv | 90 +++++++++
 tb/tb_accumulatore_prodotti.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/accumulatore_prodotti.sv
// Multiply-accumulate back end: sums N unsigned products into a saturating
// accumulator and hands the block result downstream with valid/ready.
module accumulatore_prodotti #(
    parameter int W_IN  = 4,
    parameter int W_ACC = 8,
    parameter int N     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             azzera,
    input  logic             in_valid,
    input  logic [W_IN-1:0]  in_dato,
    output logic             in_ready,
    output logic             out_valid,
    output logic [W_ACC-1:0] out_somma,
    output logic             out_ovf,
    input  logic             out_ready
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [W_ACC:0] ACC_MAX = {1'b0, {W_ACC{1'b1}}};

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t           state_q, state_d;
    logic [W_ACC-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [W_ACC:0]   sum;

    // One extra bit so an overflow of the add is visible before clamping.
    assign sum = {1'b0, acc_q} + (W_ACC+1)'(in_dato);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (azzera) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (sum > ACC_MAX) begin
                            acc_d = ACC_MAX[W_ACC-1:0];
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum[W_ACC-1:0];
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come only from registers, never from in_valid/out_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == EMIT);
    assign out_somma = acc_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_accumulatore_prodotti.sv
// Directed bench for accumulatore_prodotti: two instances (8-bit and 5-bit
// accumulators) share one stimulus and are checked against a block-sum model.
module tb_accumulatore_prodotti;
    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0, azzera = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] in_dato = '0;

    logic       rdy8, vld8, ovf8, rdy5, vld5, ovf5;
    logic [7:0] som8;
    logic [4:0] som5;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    accumulatore_prodotti #(.W_IN(4), .W_ACC(8), .N(N)) dut8 (
        .clock(clock), .reset(reset), .azzera(azzera), .in_valid(in_valid),
        .in_dato(in_dato), .in_ready(rdy8), .out_valid(vld8), .out_somma(som8),
        .out_ovf(ovf8), .out_ready(out_ready));

    accumulatore_prodotti #(.W_IN(4), .W_ACC(5), .N(N)) dut5 (
        .clock(clock), .reset(reset), .azzera(azzera), .in_valid(in_valid),
        .in_dato(in_dato), .in_ready(rdy5), .out_valid(vld5), .out_somma(som5),
        .out_ovf(ovf5), .out_ready(out_ready));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: unbounded true sum of the block; saturation is min(sum, max),
    // overflow flag is sum > max (products are non-negative).
    bit m_live = 0;
    bit m_emit = 0;
    int m_sum  = 0;
    int m_cnt  = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_live <= 1; m_emit <= 0; m_sum <= 0; m_cnt <= 0;
        end else if (azzera) begin
            m_emit <= 0; m_sum <= 0; m_cnt <= 0;
        end else if (m_emit) begin
            if (out_ready) begin
                m_emit <= 0; m_sum <= 0; m_cnt <= 0;
            end
        end else if (in_valid) begin
            m_sum  <= m_sum + int'(in_dato);
            m_cnt  <= m_cnt + 1;
            m_emit <= (m_cnt + 1 == N);
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            chk("m8_in_ready", int'(rdy8), int'(!m_emit));
            chk("m8_out_valid", int'(vld8), int'(m_emit));
            chk("m5_in_ready", int'(rdy5), int'(!m_emit));
            chk("m5_out_valid", int'(vld5), int'(m_emit));
            if (m_emit) begin
                chk("m8_somma", int'(som8), (m_sum > 255) ? 255 : m_sum);
                chk("m8_ovf", int'(ovf8), int'(m_sum > 255));
                chk("m5_somma", int'(som5), (m_sum > 31) ? 31 : m_sum);
                chk("m5_ovf", int'(ovf5), int'(m_sum > 31));
            end
        end
    end

    task automatic step(input logic v, input logic [3:0] d, input logic ordy,
                        input logic az = 1'b0, input logic rst = 1'b0);
        in_valid = v; in_dato = d; out_ready = ordy; azzera = az; reset = rst;
        @(posedge clock);
        #1;
        in_valid = 1'b0; azzera = 1'b0; reset = 1'b0; out_ready = 1'b0;
    endtask

    task automatic block4(input logic [3:0] a, b, c, d);
        step(1, a, 0); step(1, b, 0); step(1, c, 0); step(1, d, 0);
    endtask

    logic rec_v [10];
    int   rec_s [10];

    initial begin
        // reset state
        step(0, 0, 0, 0, 1);
        chk("rst_in_ready", int'(rdy8), 1);
        chk("rst_out_valid", int'(vld8), 0);
        chk("rst_somma", int'(som8), 0);
        chk("rst_ovf", int'(ovf8), 0);

        // basic block 0,2,6,1
        block4(0, 2, 6, 1);
        chk("basic_valid", int'(vld8), 1);
        chk("basic_somma", int'(som8), 9);
        chk("basic_ovf", int'(ovf8), 0);
        step(0, 0, 0);
        chk("basic_hold_ready", int'(rdy8), 0);
        step(0, 0, 1);
        chk("basic_after_xfer_ready", int'(rdy8), 1);
        chk("basic_after_xfer_valid", int'(vld8), 0);

        // saturation on the 5-bit instance, then ovf cleared
        block4(9, 9, 9, 9);
        chk("sat5_somma", int'(som5), 31);
        chk("sat5_ovf", int'(ovf5), 1);
        chk("sat8_somma", int'(som8), 36);
        step(0, 0, 1);
        block4(1, 1, 1, 1);
        chk("sat5_next_somma", int'(som5), 4);
        chk("sat5_next_ovf", int'(ovf5), 0);
        step(0, 0, 1);

        // backpressure with 2s offered while stalled
        block4(3, 3, 3, 3);
        for (int i = 0; i < 5; i++) begin
            step(1, 2, 0);
            chk("bp_valid", int'(vld8), 1);
            chk("bp_somma", int'(som8), 12);
            chk("bp_ready", int'(rdy8), 0);
        end
        step(1, 2, 1);
        chk("bp_xfer_ready", int'(rdy8), 1);
        block4(2, 2, 2, 2);
        chk("bp_next_somma", int'(som8), 8);
        step(0, 0, 1);

        // gaps: 2,_,_,6,_,1,3
        step(1, 2, 0); step(0, 7, 0); step(0, 7, 0); step(1, 6, 0);
        step(0, 7, 0); step(1, 1, 0);
        chk("gap_not_done", int'(vld8), 0);
        step(1, 3, 0);
        chk("gap_valid", int'(vld8), 1);
        chk("gap_somma", int'(som8), 12);
        step(0, 0, 1);

        // azzera mid-block, with an input offered on the clear cycle
        step(1, 6, 0); step(1, 6, 0);
        step(1, 5, 0, 1);
        block4(1, 1, 1, 1);
        chk("clr_somma", int'(som8), 4);
        step(0, 0, 1);

        // reset during EMIT, even with out_ready high
        block4(6, 6, 6, 6);
        step(0, 0, 1, 0, 1);
        chk("rst_emit_valid", int'(vld8), 0);
        chk("rst_emit_ready", int'(rdy8), 1);
        block4(1, 2, 3, 4);
        chk("rst_emit_next_somma", int'(som8), 10);
        step(0, 0, 1);

        // azzera during EMIT beats out_ready
        block4(1, 1, 1, 1);
        step(0, 0, 1, 1);
        chk("az_emit_valid", int'(vld8), 0);
        block4(2, 2, 2, 2);
        chk("az_emit_next_somma", int'(som8), 8);
        step(0, 0, 1);

        // back-to-back with out_ready tied high; EMIT-cycle datum ignored
        begin
            logic [3:0] seq [10];
            seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd2, 4'd2, 4'd2, 4'd2, 4'd9};
            for (int i = 0; i < 10; i++) begin
                step(1, seq[i], 1);
                rec_v[i] = vld8;
                rec_s[i] = int'(som8);
            end
        end
        for (int i = 0; i < 10; i++)
            chk($sformatf("b2b_valid_%0d", i), int'(rec_v[i]), int'(i == 3 || i == 8));
        chk("b2b_somma_1", rec_s[3], 10);
        chk("b2b_somma_2", rec_s[8], 8);

        step(0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
